// File: rtl/dmem_ctrl_pkg.sv
// Shared types and helpers for the data memory controller: FSM states,
// RV32I load/store funct3 codes, lane steering and load extension.
package dmem_ctrl_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic funct3_legal(input logic is_store, input logic [2:0] f3);
    case (f3)
      F3_B, F3_H, F3_W: return 1'b1;
      F3_BU, F3_HU:     return !is_store;
      default:          return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_B:    return 4'b0001 << off;
      F3_H:    return off[1] ? 4'b1100 : 4'b0011;
      F3_W:    return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  // Replicate narrow store data so every candidate lane sees the right bytes.
  function automatic logic [31:0] store_steer(input logic [2:0] f3, input logic [31:0] wd);
    case (f3)
      F3_B:    return {4{wd[7:0]}};
      F3_H:    return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_B:    return {{24{b[7]}}, b};
      F3_BU:   return {24'h000000, b};
      F3_H:    return {{16{h[15]}}, h};
      F3_HU:   return {16'h0000, h};
      default: return word;
    endcase
  endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// Load/store unit to data memory controller request/response bundle.
interface dmem_ctrl_if;
  logic        req;
  logic        we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wr_data;
  logic        ready;
  logic        done;
  logic        fault;
  logic [31:0] rd_data;

  modport master (output req, we, funct3, addr, wr_data,
                  input  ready, done, fault, rd_data);
  modport slave  (input  req, we, funct3, addr, wr_data,
                  output ready, done, fault, rd_data);
endinterface

// File: rtl/dmem_ctrl_bank.sv
// One byte lane of data memory: DEPTH bytes, synchronous write and read.
module dmem_bank #(
  parameter int ADDR_BITS = 14,
  parameter int DEPTH     = 16384
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] index,
  input  logic [7:0]           wr_data,
  output logic [7:0]           rd_data
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[index] <= wr_data;
    rd_data <= mem[index];
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Word-wide data memory controller over four byte-lane banks: decodes
// funct3, steers lanes, extends loads and rejects illegal accesses.
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int ADDR_BITS   = 14,
  parameter int DEPTH       = 16384,
  parameter int WAIT_STATES = 0
) (
  input logic        clk,
  input logic        rst,
  dmem_ctrl_if.slave bus
);

  state_t                 state;
  logic [3:0]             cnt;
  logic                   we_q;
  logic [2:0]             f3_q;
  logic [1:0]             off_q;
  logic [ADDR_BITS-1:0]   idx_q;
  logic [31:0]            wdata_q;
  logic                   fault_q;
  logic                   done_r;
  logic                   fault_r;
  logic [31:0]            rd_r;

  logic [ADDR_BITS-1:0]   req_idx;
  logic                   req_fault;
  logic [ADDR_BITS-1:0]   bank_idx;
  logic [3:0]             lane_we;
  logic [31:0]            lane_wdata;
  logic [31:0]            bank_rdata;

  assign req_idx = bus.addr[ADDR_BITS+1:2];

  always_comb begin
    req_fault = !funct3_legal(bus.we, bus.funct3);
    if (bus.funct3[1:0] == 2'b01 && bus.addr[0]) req_fault = 1'b1;
    if (bus.funct3[1:0] == 2'b10 && bus.addr[1:0] != 2'b00) req_fault = 1'b1;
    if (32'(req_idx) >= 32'(DEPTH)) req_fault = 1'b1;
    if ((bus.addr >> (ADDR_BITS + 2)) != 32'd0) req_fault = 1'b1;
  end

  // Banks read the incoming address while idle so the word is already
  // registered by the access edge, even with zero wait states.
  assign bank_idx   = (state == ST_IDLE) ? req_idx : idx_q;
  assign lane_wdata = store_steer(f3_q, wdata_q);

  always_comb begin
    lane_we = 4'b0000;
    if (state == ST_BUSY && cnt == 4'd0 && we_q && !fault_q)
      lane_we = lane_mask(f3_q, off_q);
  end

  for (genvar l = 0; l < 4; l++) begin : g_lane
    dmem_bank #(.ADDR_BITS(ADDR_BITS), .DEPTH(DEPTH)) u_bank (
      .clk     (clk),
      .we      (lane_we[l]),
      .index   (bank_idx),
      .wr_data (lane_wdata[8*l +: 8]),
      .rd_data (bank_rdata[8*l +: 8])
    );
  end

  // Fault is decided at acceptance; the access edge only publishes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= 4'd0;
      done_r  <= 1'b0;
      fault_r <= 1'b0;
      rd_r    <= 32'd0;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      off_q   <= 2'b00;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      fault_q <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.req) begin
            we_q    <= bus.we;
            f3_q    <= bus.funct3;
            off_q   <= bus.addr[1:0];
            idx_q   <= req_idx;
            wdata_q <= bus.wr_data;
            fault_q <= req_fault;
            cnt     <= 4'(WAIT_STATES);
            state   <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            done_r  <= 1'b1;
            fault_r <= fault_q;
            rd_r    <= (fault_q || we_q) ? 32'd0 : load_extend(f3_q, off_q, bank_rdata);
            state   <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.ready   = (state == ST_IDLE);
  assign bus.done    = done_r;
  assign bus.fault   = fault_r;
  assign bus.rd_data = rd_r;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: one instance with no wait states and
// one with three wait states and a shallow memory.
module tb_dmem_ctrl;
  import dmem_ctrl_pkg::*;

  typedef struct {
    int          dut;
    logic        fault;
    logic        chk_rd;
    logic [31:0] rd;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_ctrl_if b0 ();
  dmem_ctrl_if b3 ();

  dmem_ctrl #(.ADDR_BITS(14), .DEPTH(16384), .WAIT_STATES(0)) u_dut0 (
    .clk (clk), .rst (rst), .bus (b0.slave));
  dmem_ctrl #(.ADDR_BITS(14), .DEPTH(1024), .WAIT_STATES(3)) u_dut3 (
    .clk (clk), .rst (rst), .bus (b3.slave));

  logic [1:0]  req_s, we_s;
  logic [2:0]  f3_s [2];
  logic [31:0] addr_s [2];
  logic [31:0] wd_s [2];
  logic [1:0]  ready_v, done_v, fault_v;
  logic [31:0] rd_v [2];

  assign b0.req = req_s[0];  assign b0.we = we_s[0];  assign b0.funct3 = f3_s[0];
  assign b0.addr = addr_s[0]; assign b0.wr_data = wd_s[0];
  assign b3.req = req_s[1];  assign b3.we = we_s[1];  assign b3.funct3 = f3_s[1];
  assign b3.addr = addr_s[1]; assign b3.wr_data = wd_s[1];
  assign ready_v = {b3.ready, b0.ready};
  assign done_v  = {b3.done, b0.done};
  assign fault_v = {b3.fault, b0.fault};
  assign rd_v[0] = b0.rd_data;
  assign rd_v[1] = b3.rd_data;

  exp_t exp_q [$];
  exp_t mon_e;
  int   busy_cnt [2];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per done pulse; busy_cnt counts ready-low cycles.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        busy_cnt[d] = 0;
      end else begin
        busy_cnt[d] = ready_v[d] ? 0 : busy_cnt[d] + 1;
        if (done_v[d]) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL unexpected_done: dut %0d pulsed done, expected no pulse", d);
          end else begin
            mon_e = exp_q.pop_front();
            checkOutput({mon_e.name, " dut"}, 32'(d), 32'(mon_e.dut));
            checkOutput({mon_e.name, " fault"}, {31'd0, fault_v[d]}, {31'd0, mon_e.fault});
            if (mon_e.chk_rd) checkOutput({mon_e.name, " rd"}, rd_v[d], mon_e.rd);
            checkOutput({mon_e.name, " busy"}, 32'(busy_cnt[d]), (d == 0) ? 32'd2 : 32'd5);
          end
        end
      end
    end
  end

  task automatic applyStimulus(input int d, input logic w, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] wd,
                               input logic exp_fault, input logic [31:0] exp_rd,
                               input string name, input bit hold, input bit rst_at_done);
    exp_t e;
    int   n;
    e.dut = d; e.fault = exp_fault; e.chk_rd = !w; e.rd = exp_rd; e.name = name;
    exp_q.push_back(e);
    @(negedge clk);
    we_s[d] = w; f3_s[d] = f3; addr_s[d] = a; wd_s[d] = wd; req_s[d] = 1'b1;
    n = 0;
    while (!ready_v[d] && n < 50) begin @(negedge clk); n++; end
    @(posedge clk);
    #1;
    addr_s[d] = ~a; wd_s[d] = 32'h5A5A_5A5A; f3_s[d] = ~f3;
    if (!hold) req_s[d] = 1'b0;
    n = 0;
    @(negedge clk);
    while (!done_v[d] && n < 50) begin @(negedge clk); n++; end
    if (!done_v[d]) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL %s timeout: no done within 50 cycles, expected done", name);
    end
    req_s[d] = 1'b0;
    if (rst_at_done) begin
      #2 rst = 1'b1;
      #1 checkOutput({name, " done_rst"}, {31'd0, done_v[d]}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
    end else begin
      @(negedge clk);
      checkOutput({name, " ready"}, {31'd0, ready_v[d]}, 32'd1);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    req_s = 2'b00; we_s = 2'b00;
    for (int d = 0; d < 2; d++) begin f3_s[d] = 3'b000; addr_s[d] = 32'd0; wd_s[d] = 32'd0; end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      checkOutput("reset ready", {31'd0, ready_v[d]}, 32'd1);
      checkOutput("reset done",  {31'd0, done_v[d]},  32'd0);
      checkOutput("reset fault", {31'd0, fault_v[d]}, 32'd0);
      checkOutput("reset rd",    rd_v[d],             32'd0);
    end

    // Zero wait states, full-depth memory
    applyStimulus(0, 1'b1, F3_W,  32'h10, 32'hDEADBEEF, 1'b0, 32'h0,        "sw_10",   0, 0);
    applyStimulus(0, 1'b0, F3_W,  32'h10, 32'h0,        1'b0, 32'hDEADBEEF, "lw_10",   0, 0);
    applyStimulus(0, 1'b1, F3_B,  32'h11, 32'h12345680, 1'b0, 32'h0,        "sb_11",   0, 0);
    applyStimulus(0, 1'b0, F3_B,  32'h11, 32'h0,        1'b0, 32'hFFFFFF80, "lb_11",   0, 0);
    applyStimulus(0, 1'b0, F3_BU, 32'h11, 32'h0,        1'b0, 32'h00000080, "lbu_11",  0, 0);
    applyStimulus(0, 1'b0, F3_W,  32'h10, 32'h0,        1'b0, 32'hDEAD80EF, "lw_sb",   0, 0);
    applyStimulus(0, 1'b1, F3_H,  32'h12, 32'hABCD1234, 1'b0, 32'h0,        "sh_12",   0, 0);
    applyStimulus(0, 1'b0, F3_W,  32'h10, 32'h0,        1'b0, 32'h123480EF, "lw_sh",   0, 0);
    applyStimulus(0, 1'b0, F3_H,  32'h12, 32'h0,        1'b0, 32'h00001234, "lh_12",   0, 0);
    applyStimulus(0, 1'b0, F3_HU, 32'h10, 32'h0,        1'b0, 32'h000080EF, "lhu_10",  0, 0);
    applyStimulus(0, 1'b0, F3_H,  32'h10, 32'h0,        1'b0, 32'hFFFF80EF, "lh_10",   0, 0);
    applyStimulus(0, 1'b0, F3_B,  32'h13, 32'h0,        1'b0, 32'h00000012, "lb_13",   0, 0);
    applyStimulus(0, 1'b0, F3_W,  32'h13, 32'h0,        1'b1, 32'h0,        "lw_mis",  0, 0);
    applyStimulus(0, 1'b1, F3_H,  32'h11, 32'h0000FFFF, 1'b1, 32'h0,        "sh_mis",  0, 0);
    applyStimulus(0, 1'b0, F3_W,  32'h10, 32'h0,        1'b0, 32'h123480EF, "lw_after",0, 0);
    applyStimulus(0, 1'b0, 3'b011,32'h10, 32'h0,        1'b1, 32'h0,        "ld_f3_011",0, 0);
    applyStimulus(0, 1'b1, F3_BU, 32'h10, 32'h000000AA, 1'b1, 32'h0,        "st_f3_100",0, 0);
    applyStimulus(0, 1'b0, F3_HU, 32'h11, 32'h0,        1'b1, 32'h0,        "lhu_mis", 0, 0);
    applyStimulus(0, 1'b1, F3_W,  32'h10000, 32'h01020304, 1'b1, 32'h0,     "sw_depth",0, 0);
    applyStimulus(0, 1'b0, F3_W,  32'h80000010, 32'h0,  1'b1, 32'h0,        "lw_hi",   0, 0);
    applyStimulus(0, 1'b1, F3_W,  32'hFFFC, 32'h0BADF00D, 1'b0, 32'h0,      "sw_last", 0, 0);
    applyStimulus(0, 1'b0, F3_W,  32'hFFFC, 32'h0,      1'b0, 32'h0BADF00D, "lw_last", 0, 0);
    applyStimulus(0, 1'b0, F3_W,  32'h10, 32'h0,        1'b0, 32'h123480EF, "lw_final",0, 0);

    // Three wait states, 1024-word memory
    applyStimulus(1, 1'b1, F3_W,  32'h20, 32'h11223344, 1'b0, 32'h0,        "sw3_20",  0, 0);
    applyStimulus(1, 1'b0, F3_W,  32'h20, 32'h0,        1'b0, 32'h11223344, "lw3_hold",1, 0);
    applyStimulus(1, 1'b1, F3_W,  32'h1000, 32'hFFFFFFFF, 1'b1, 32'h0,      "sw3_depth",0, 0);
    applyStimulus(1, 1'b1, F3_W,  32'hFFC, 32'h55AA33CC, 1'b0, 32'h0,       "sw3_last",0, 0);
    applyStimulus(1, 1'b0, F3_W,  32'hFFC, 32'h0,       1'b0, 32'h55AA33CC, "lw3_last",0, 0);

    // Reset while a store is still counting down its wait states
    @(negedge clk);
    we_s[1] = 1'b1; f3_s[1] = F3_W; addr_s[1] = 32'h20; wd_s[1] = 32'hCAFEF00D; req_s[1] = 1'b1;
    @(posedge clk);
    #1 req_s[1] = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_busy ready", {31'd0, ready_v[1]}, 32'd1);
    repeat (8) @(negedge clk);

    applyStimulus(1, 1'b0, F3_W,  32'h20, 32'h0,        1'b0, 32'h11223344, "lw3_after_rst", 0, 0);
    applyStimulus(1, 1'b0, F3_B,  32'h23, 32'h0,        1'b0, 32'h00000011, "lb3_rstdone",   0, 1);
    applyStimulus(1, 1'b0, F3_HU, 32'h22, 32'h0,        1'b0, 32'h00001122, "lhu3_recover",  0, 0);
    applyStimulus(0, 1'b0, F3_W,  32'h10, 32'h0,        1'b0, 32'h123480EF, "lw_post_rst",   0, 0);

    repeat (4) @(negedge clk);
    checkOutput("pending", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
